// File: rtl/color_palette_mapper.sv
// color_palette_mapper
//
// Converts a 2-bit pixel-index stream into 24-bit RGB using a four-entry
// palette taken from the colour register block. The palette is copied into a
// shadow set on every accepted start-of-frame pixel, so CPU writes to the
// colour registers never change colours part-way through a frame. Output is
// buffered in a 2-entry FIFO. The block also counts frames, checks line length
// and flags pixels that arrive outside a frame.
//
// Optional feature macro: PALETTE_TRANSPARENCY_EN
//   defined   : palette words with bit 31 set produce BG_COLOR and m_pix_transp = 1
//   undefined : bit 31 is ignored and m_pix_transp is always 0
//
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   color_reg0..color_reg3   palette words: [23:0] RGB, [31] transparent flag
//   s_pix_*                  input index stream (valid/ready, index, sof, eol)
//   m_pix_*                  output RGB stream (valid/ready, rgb, sof, eol, transp)
//   frame_cnt                number of accepted SOF pixels, wraps
//   err_sync                 sticky: pixels dropped while no frame was active
//   err_line                 sticky: line length did not match LINE_WIDTH
//   err_clear                synchronous clear for both sticky flags

module color_palette_mapper #(
    parameter int          LINE_WIDTH  = 640,
    parameter int          FRAME_CNT_W = 16,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [31:0]            color_reg0,
    input  logic [31:0]            color_reg1,
    input  logic [31:0]            color_reg2,
    input  logic [31:0]            color_reg3,
    input  logic                   s_pix_valid,
    output logic                   s_pix_ready,
    input  logic [1:0]             s_pix_index,
    input  logic                   s_pix_sof,
    input  logic                   s_pix_eol,
    output logic                   m_pix_valid,
    input  logic                   m_pix_ready,
    output logic [23:0]            m_pix_rgb,
    output logic                   m_pix_sof,
    output logic                   m_pix_eol,
    output logic                   m_pix_transp,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_sync,
    output logic                   err_line,
    input  logic                   err_clear
);

    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        transp;
    } pix_t;

    state_t      state;
    state_t      next_state;

    // Palette entries are kept as {transparent flag, RGB}.
    logic [24:0] live_pal   [4];
    logic [24:0] shadow_pal [4];
    logic [24:0] sel_word;
    pix_t        push_pix;

    pix_t        fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        ready_q;

    logic          accept;
    logic          push;
    logic          pop;
    logic          drop;
    logic [XW-1:0] x_cnt;
    logic [XW-1:0] cur_x;
    logic          line_set;

    assign live_pal[0] = {color_reg0[31], color_reg0[23:0]};
    assign live_pal[1] = {color_reg1[31], color_reg1[23:0]};
    assign live_pal[2] = {color_reg2[31], color_reg2[23:0]};
    assign live_pal[3] = {color_reg3[31], color_reg3[23:0]};

    assign s_pix_ready = ready_q;
    assign accept      = s_pix_valid & ready_q;
    assign push        = accept & ((state == ACTIVE) | s_pix_sof);
    assign drop        = accept & (state == IDLE) & ~s_pix_sof;
    assign pop         = (count != 2'd0) & m_pix_ready;

    assign m_pix_valid  = (count != 2'd0);
    assign m_pix_rgb    = fifo_mem[rd_ptr].rgb;
    assign m_pix_sof    = fifo_mem[rd_ptr].sof;
    assign m_pix_eol    = fifo_mem[rd_ptr].eol;
    assign m_pix_transp = fifo_mem[rd_ptr].transp;

    // The SOF pixel must already see the new palette, so it reads the live
    // registers while the shadow copy is being loaded on the same edge.
    always_comb begin
        sel_word = s_pix_sof ? live_pal[s_pix_index] : shadow_pal[s_pix_index];
        push_pix        = '0;
        push_pix.rgb    = sel_word[23:0];
        push_pix.sof    = s_pix_sof;
        push_pix.eol    = s_pix_eol;
        push_pix.transp = 1'b0;
`ifdef PALETTE_TRANSPARENCY_EN
        if (sel_word[24]) begin
            push_pix.rgb    = BG_COLOR;
            push_pix.transp = 1'b1;
        end
`endif
    end

`ifdef PALETTE_TRANSPARENCY_EN
    logic unused_bits;
    assign unused_bits = ^{color_reg0[30:24], color_reg1[30:24],
                           color_reg2[30:24], color_reg3[30:24]};
`else
    logic unused_bits;
    assign unused_bits = ^{color_reg0[30:24], color_reg1[30:24],
                           color_reg2[30:24], color_reg3[30:24],
                           sel_word[24], BG_COLOR};
`endif

    // Frame tracking: any accepted SOF enters (or re-enters) the active frame.
    always_comb begin
        next_state = state;
        if (accept && s_pix_sof) begin
            next_state = ACTIVE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Ready is registered from the next occupancy so it never depends
    // combinationally on m_pix_ready; the FIFO can therefore never overflow.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_pix;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                shadow_pal[i] <= '0;
            end
            frame_cnt <= '0;
        end else if (accept && s_pix_sof) begin
            for (int i = 0; i < 4; i++) begin
                shadow_pal[i] <= live_pal[i];
            end
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    // The SOF pixel is always column 0, whatever the counter held before.
    assign cur_x    = s_pix_sof ? '0 : x_cnt;
    assign line_set = push & ((s_pix_eol & (cur_x != X_LAST)) |
                              (~s_pix_eol & (cur_x == X_LAST)));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            x_cnt <= '0;
        end else if (push) begin
            if (s_pix_eol || (cur_x == X_LAST)) begin
                x_cnt <= '0;
            end else begin
                x_cnt <= cur_x + XW'(1);
            end
        end
    end

    // A new error in the same cycle as a clear must survive the clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_sync <= 1'b0;
            err_line <= 1'b0;
        end else begin
            err_sync <= drop | (err_sync & ~err_clear);
            err_line <= line_set | (err_line & ~err_clear);
        end
    end

endmodule

// File: tb/tb_color_palette_mapper.sv
// Self-checking bench for color_palette_mapper.
// Expected output pixels come from a small palette/frame model and are queued
// when a pixel is accepted; a monitor pops and compares them as the DUT
// delivers pixels. Directed checks cover reset, errors, latency and stalls.

module tb_color_palette_mapper;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] color_reg0, color_reg1, color_reg2, color_reg3;
    logic        s_pix_valid;
    logic        s_pix_ready;
    logic [1:0]  s_pix_index;
    logic        s_pix_sof;
    logic        s_pix_eol;
    logic        m_pix_valid;
    logic        m_pix_ready;
    logic [23:0] m_pix_rgb;
    logic        m_pix_sof;
    logic        m_pix_eol;
    logic        m_pix_transp;
    logic [15:0] frame_cnt;
    logic        err_sync;
    logic        err_line;
    logic        err_clear;

    int n_vec  = 0;
    int n_miss = 0;

    logic [26:0] exp_q[$];
    logic        m_active;
    logic [31:0] m_shadow [4];
    int          m_frames;

    color_palette_mapper #(
        .LINE_WIDTH  (4),
        .FRAME_CNT_W (16),
        .BG_COLOR    (24'h101010)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .color_reg0   (color_reg0),
        .color_reg1   (color_reg1),
        .color_reg2   (color_reg2),
        .color_reg3   (color_reg3),
        .s_pix_valid  (s_pix_valid),
        .s_pix_ready  (s_pix_ready),
        .s_pix_index  (s_pix_index),
        .s_pix_sof    (s_pix_sof),
        .s_pix_eol    (s_pix_eol),
        .m_pix_valid  (m_pix_valid),
        .m_pix_ready  (m_pix_ready),
        .m_pix_rgb    (m_pix_rgb),
        .m_pix_sof    (m_pix_sof),
        .m_pix_eol    (m_pix_eol),
        .m_pix_transp (m_pix_transp),
        .frame_cnt    (frame_cnt),
        .err_sync     (err_sync),
        .err_line     (err_line),
        .err_clear    (err_clear)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_frames = 0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 32'h0;
    endtask

    // Reference behaviour for one accepted pixel.
    task automatic model_accept(input logic [1:0] idx, input logic sof, input logic eol);
        logic [31:0] w;
        logic [23:0] rgb;
        logic        tr;
        if (m_active || sof) begin
            if (sof) begin
                m_shadow[0] = color_reg0;
                m_shadow[1] = color_reg1;
                m_shadow[2] = color_reg2;
                m_shadow[3] = color_reg3;
                m_active    = 1'b1;
                m_frames++;
            end
            w   = m_shadow[idx];
            rgb = w[23:0];
            tr  = 1'b0;
`ifdef PALETTE_TRANSPARENCY_EN
            if (w[31]) begin
                rgb = 24'h101010;
                tr  = 1'b1;
            end
`endif
            exp_q.push_back({rgb, sof, eol, tr});
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic apply_stimulus(input logic [1:0] idx, input logic sof, input logic eol);
        int waited = 0;
        s_pix_valid = 1'b1;
        s_pix_index = idx;
        s_pix_sof   = sof;
        s_pix_eol   = eol;
        while (!s_pix_ready && waited < 30) begin
            @(negedge ACLK);
            waited++;
        end
        if (!s_pix_ready) begin
            check_output("accept_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(idx, sof, eol);
            @(negedge ACLK);
        end
        s_pix_valid = 1'b0;
        s_pix_sof   = 1'b0;
        s_pix_eol   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) check_output("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge ACLK);
        err_clear = 1'b0;
    endtask

    // Output monitor: a transfer happens on the next rising edge whenever
    // valid and ready are both high half a cycle before it.
    always @(negedge ACLK) begin
        #1;
        if (ARESETN && m_pix_valid && m_pix_ready) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_out", {5'b0, m_pix_rgb, m_pix_sof, m_pix_eol, m_pix_transp}, 32'd0);
            end else begin
                check_output("pix_out", {5'b0, m_pix_rgb, m_pix_sof, m_pix_eol, m_pix_transp},
                             {5'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [26:0] head;
        ARESETN     = 1'b0;
        color_reg0  = 32'h0;
        color_reg1  = 32'h0;
        color_reg2  = 32'h0;
        color_reg3  = 32'h0;
        s_pix_valid = 1'b0;
        s_pix_index = 2'd0;
        s_pix_sof   = 1'b0;
        s_pix_eol   = 1'b0;
        m_pix_ready = 1'b0;
        err_clear   = 1'b0;
        model_reset();

        repeat (3) @(negedge ACLK);
        check_output("rst_m_valid", {31'b0, m_pix_valid}, 32'd0);
        check_output("rst_s_ready", {31'b0, s_pix_ready}, 32'd0);
        check_output("rst_m_pix", {5'b0, m_pix_rgb, m_pix_sof, m_pix_eol, m_pix_transp}, 32'd0);
        check_output("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check_output("rst_err", {30'b0, err_sync, err_line}, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_output("ready_after_rst", {31'b0, s_pix_ready}, 32'd1);

        // Pixels before any SOF are dropped and flag a sync error.
        m_pix_ready = 1'b1;
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b0);
        apply_stimulus(2'd3, 1'b0, 1'b0);
        check_output("err_sync_set", {31'b0, err_sync}, 32'd1);
        check_output("sync_no_out", {31'b0, m_pix_valid}, 32'd0);
        pulse_clear();
        check_output("err_sync_clear", {31'b0, err_sync}, 32'd0);

        // Basic frame mapping with one-cycle latency.
        color_reg0 = 32'h00FF0000;
        color_reg1 = 32'h0000FF00;
        color_reg2 = 32'h000000FF;
        color_reg3 = 32'h00FFFFFF;
        apply_stimulus(2'd0, 1'b1, 1'b0);
        check_output("lat_valid", {31'b0, m_pix_valid}, 32'd1);
        check_output("lat_rgb", {8'b0, m_pix_rgb}, 32'h00FF0000);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b0);
        apply_stimulus(2'd3, 1'b0, 1'b1);
        wait_drain();
        check_output("frame_cnt_1", {16'b0, frame_cnt}, 32'd1);
        check_output("no_line_err", {31'b0, err_line}, 32'd0);

        // Register write mid-frame must not show until the next SOF.
        apply_stimulus(2'd1, 1'b1, 1'b0);
        color_reg1 = 32'h00123456;
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd0, 1'b0, 1'b1);
        wait_drain();
        apply_stimulus(2'd1, 1'b1, 1'b0);
        check_output("new_pal_rgb", {8'b0, m_pix_rgb}, 32'h00123456);
        apply_stimulus(2'd2, 1'b0, 1'b0);
        apply_stimulus(2'd3, 1'b0, 1'b0);
        apply_stimulus(2'd0, 1'b0, 1'b1);
        wait_drain();
        check_output("frame_cnt_3", {16'b0, frame_cnt}, 32'd3);

        // Backpressure: two accepts fill the FIFO, outputs hold while stalled.
        m_pix_ready = 1'b0;
        apply_stimulus(2'd0, 1'b1, 1'b0);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        check_output("bp_s_ready", {31'b0, s_pix_ready}, 32'd0);
        fork
            begin
                apply_stimulus(2'd2, 1'b0, 1'b0);
                apply_stimulus(2'd3, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge ACLK);
                    head = exp_q[0];
                    check_output("bp_hold_valid", {31'b0, m_pix_valid}, 32'd1);
                    check_output("bp_hold_pix", {5'b0, m_pix_rgb, m_pix_sof, m_pix_eol, m_pix_transp},
                                 {5'b0, head});
                end
                m_pix_ready = 1'b1;
            end
        join
        wait_drain();
        check_output("frame_cnt_bp", {16'b0, frame_cnt}, m_frames);

        // Line-length errors: short line, missing EOL, clear vs set.
        apply_stimulus(2'd0, 1'b1, 1'b0);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b1);
        check_output("err_line_short", {31'b0, err_line}, 32'd1);
        pulse_clear();
        check_output("err_line_clear", {31'b0, err_line}, 32'd0);
        apply_stimulus(2'd0, 1'b0, 1'b0);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b0);
        check_output("err_line_not_yet", {31'b0, err_line}, 32'd0);
        apply_stimulus(2'd3, 1'b0, 1'b0);
        check_output("err_line_no_eol", {31'b0, err_line}, 32'd1);
        pulse_clear();
        check_output("err_line_clear2", {31'b0, err_line}, 32'd0);
        err_clear = 1'b1;
        apply_stimulus(2'd1, 1'b0, 1'b1);
        err_clear = 1'b0;
        check_output("clear_vs_set", {31'b0, err_line}, 32'd1);
        wait_drain();

        // Transparent palette entry.
        color_reg2 = 32'h80ABCDEF;
        apply_stimulus(2'd2, 1'b1, 1'b0);
`ifdef PALETTE_TRANSPARENCY_EN
        check_output("transp_rgb", {8'b0, m_pix_rgb}, 32'h00101010);
        check_output("transp_flag", {31'b0, m_pix_transp}, 32'd1);
`else
        check_output("transp_rgb", {8'b0, m_pix_rgb}, 32'h00ABCDEF);
        check_output("transp_flag", {31'b0, m_pix_transp}, 32'd0);
`endif
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b0);
        apply_stimulus(2'd3, 1'b0, 1'b1);
        wait_drain();

        // Reset with a full FIFO discards everything immediately.
        m_pix_ready = 1'b0;
        apply_stimulus(2'd0, 1'b1, 1'b0);
        apply_stimulus(2'd3, 1'b0, 1'b0);
        check_output("full_s_ready", {31'b0, s_pix_ready}, 32'd0);
        ARESETN = 1'b0;
        #1;
        check_output("rst_mid_valid", {31'b0, m_pix_valid}, 32'd0);
        check_output("rst_mid_s_ready", {31'b0, s_pix_ready}, 32'd0);
        model_reset();
        repeat (2) @(negedge ACLK);
        ARESETN     = 1'b1;
        m_pix_ready = 1'b1;
        @(negedge ACLK);
        check_output("rst_mid_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check_output("rst_mid_err", {30'b0, err_sync, err_line}, 32'd0);
        check_output("rst_mid_empty", {31'b0, m_pix_valid}, 32'd0);

        apply_stimulus(2'd3, 1'b1, 1'b0);
        apply_stimulus(2'd0, 1'b0, 1'b0);
        apply_stimulus(2'd1, 1'b0, 1'b0);
        apply_stimulus(2'd2, 1'b0, 1'b1);
        wait_drain();
        check_output("frame_cnt_post_rst", {16'b0, frame_cnt}, m_frames);
        check_output("leftover", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/color_palette_mapper.md
Name: color_palette_mapper

Overview:
- Sits directly downstream of the colour register AXI4-Lite slave. Consumes its four 32-bit colour registers and converts a 2-bit pixel-index stream from the tile/sprite renderer into a 24-bit RGB stream for the video output stage.
- Registers are latched into a shadow palette at start of frame, so CPU writes never tear a frame.
- Also tracks line length, counts frames, and flags stream sync errors.

Parameters:
- LINE_WIDTH, 640, accepted pixels per line; EOL expected on pixel LINE_WIDTH-1.
- FRAME_CNT_W, 16, width of the frame counter.
- BG_COLOR, 24'h000000, RGB substituted for transparent entries (optional feature only).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset. Asynchronous, active-low.
- color_reg0..color_reg3  in  32 each  palette words from the colour register block. [23:0] = RGB, bit 31 = transparent flag.
- s_pix_valid  in  1  input pixel valid
- s_pix_ready  out  1  input pixel ready
- s_pix_index  in  2  palette index
- s_pix_sof  in  1  first pixel of frame
- s_pix_eol  in  1  last pixel of line
- m_pix_valid  out  1  output valid
- m_pix_ready  in  1  output ready
- m_pix_rgb  out  24  mapped colour
- m_pix_sof  out  1  SOF passed through
- m_pix_eol  out  1  EOL passed through
- m_pix_transp  out  1  transparent marker
- frame_cnt  out  FRAME_CNT_W  accepted SOF count, wraps
- err_sync  out  1  sticky: pixels dropped while not in frame
- err_line  out  1  sticky: line-length mismatch
- err_clear  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync release): shadow palette = 0, FSM = IDLE, output FIFO empty, frame_cnt = 0, x_cnt = 0, err_* = 0.
- Reset outputs: m_pix_valid = 0, m_pix_rgb/sof/eol/transp = 0, s_pix_ready = 0 while ARESETN is low.
- Accept = s_pix_valid & s_pix_ready.
- s_pix_ready = output FIFO not full. The FIFO is a 2-entry registered buffer. s_pix_ready is registered and depends on FIFO state only, never combinationally on m_pix_ready.
- Latency: a pixel accepted in cycle N with the FIFO empty is on m_pix_* in cycle N+1.
- Throughput: 1 pixel/cycle while m_pix_ready = 1.
- m_pix_* hold stable while m_pix_valid & !m_pix_ready.
- FIFO is first-in first-out. Simultaneous push and pop with the FIFO full is not possible because ready is low; with the FIFO partly filled it keeps the same occupancy.
- FSM IDLE:
  - Accepted pixel without SOF: dropped (not pushed), err_sync set.
  - Accepted pixel with SOF: goes to ACTIVE.
- FSM ACTIVE:
  - All accepted pixels are pushed to the FIFO.
  - An accepted SOF re-enters the frame; the state stays ACTIVE.
- Palette latch on accepted SOF:
  - shadow <= color_reg0..3.
  - The SOF pixel itself is mapped from color_reg* directly; later pixels use the shadow palette.
  - frame_cnt increments and wraps at 2^FRAME_CNT_W.
- Mapping: rgb = entry[s_pix_index][23:0].
- x_cnt counts accepted pushed pixels within a line:
  - It is 0 on the SOF pixel.
  - It resets to 0 after any accepted EOL.
  - EOL with x_cnt != LINE_WIDTH-1: err_line set.
  - Pixel at x_cnt == LINE_WIDTH-1 without EOL: err_line set, x_cnt wraps to 0.
- err_clear: clears both sticky flags. If clear and set occur in the same cycle, set wins.
- Mid-operation reset discards FIFO contents and palette immediately.

Optional Feature:
- Macro: PALETTE_TRANSPARENCY_EN.
- Defined: an entry with bit 31 = 1 outputs m_pix_rgb = BG_COLOR and m_pix_transp = 1.
- Undefined: bit 31 is ignored, m_pix_transp is tied to 0, and BG_COLOR is unused.

Test Plan:
- Frame mapping: regs = 0x00FF0000 / 0x0000FF00 / 0x000000FF / 0x00FFFFFF; frame of indices 0,1,2,3 with SOF on the first pixel, m_pix_ready = 1. Required: RGB out FF0000, 00FF00, 0000FF, FFFFFF, each 1 cycle after accept; frame_cnt = 1.
- Tear-free palette: change color_reg1 to 0x00123456 mid-frame. Required: the rest of the frame still outputs 00FF00 for index 1; the next SOF pixel with index 1 outputs 123456.
- Backpressure: hold m_pix_ready = 0 for 5 cycles during a stream. Required: s_pix_ready drops after 2 accepts, outputs hold stable, no pixel lost or duplicated, order preserved on release.
- Line-length error: LINE_WIDTH = 4, EOL on the 3rd pixel. Required: err_line = 1 next cycle; err_clear pulse returns it to 0; clear and set in the same cycle leave it at 1.
- Sync error: 3 pixels before any SOF after reset. Required: none output, err_sync = 1. Also assert ARESETN low while the FIFO is full; required: m_pix_valid = 0 immediately.
- With PALETTE_TRANSPARENCY_EN, BG_COLOR = 0x101010, color_reg2 = 0x80ABCDEF: index 2 outputs 101010 with m_pix_transp = 1. Without the macro it outputs ABCDEF with m_pix_transp = 0.
